// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-port to valid/ready stream adapter with a credit-based skid buffer.
// Defining FIFO_RD_STREAM_STATS_EN adds beat_cnt/stall_cnt statistics ports.
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 8
`endif

module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = `D_DATA_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int CW        = $clog2(BUF_DEPTH + 1);
  localparam int PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SW        = CW + 2;

  logic [CW-1:0]         count_q, count_d;
  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] skid_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] skid_d [BUF_DEPTH];
  logic                  run_q, run_d;

  logic          pop;
  logic          land;
  logic [SW-1:0] inflight_cnt;
  logic [SW-1:0] credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign m_valid = (count_q != '0);
  assign m_data  = skid_q[rptr_q];
  assign pop     = m_valid & m_ready;
  assign land    = inflight_q[RD_LATENCY-1];

  // Credits: a read is only issued if every word already owed to us still has a slot.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + SW'(inflight_q[i]);
    end
    credit_used = SW'(count_q) + inflight_cnt - SW'(pop);
    fifo_rd_en  = run_q & ~fifo_empty & (credit_used < SW'(BUF_DEPTH));
  end

  always_comb begin
    run_d      = 1'b1;
    count_d    = count_q + CW'(land) - CW'(pop);
    inflight_d = RD_LATENCY'({inflight_q, fifo_rd_en});
    wptr_d     = land ? ptr_inc(wptr_q) : wptr_q;
    rptr_d     = pop ? ptr_inc(rptr_q) : rptr_q;
    skid_d     = skid_q;
    if (land) begin
      skid_d[wptr_q] = fifo_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      count_q    <= '0;
      inflight_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        skid_q[i] <= '0;
      end
    end else begin
      run_q      <= run_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      skid_q     <= skid_d;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q + 32'(pop);
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !m_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(land && (count_q == CW'(BUF_DEPTH)) && !pop))
        else $error("fifo_rd_stream_adapter: word landed into a full skid buffer");
      assert (!(fifo_rd_en && fifo_empty))
        else $error("fifo_rd_stream_adapter: fifo_rd_en issued while fifo_empty");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: lane 0 uses RD_LATENCY=1, lane 1 uses RD_LATENCY=2,
// both fed by behavioural FIFO models and checked by per-lane scoreboards.
`timescale 1ns/1ps

module tb_fifo_rd_stream_adapter;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic m_ready;
  logic gap;
  logic [1:0]         fifo_empty = 2'b11;
  logic [1:0][DW-1:0] d1 = '0;
  logic [1:0][DW-1:0] d2 = '0;
  wire  [1:0]         rd_en;
  wire  [1:0]         mv;
  wire  [1:0][DW-1:0] md;

  logic [DW-1:0] fq  [2][$];
  logic [DW-1:0] exq [2][$];
  int tests = 0;
  int fails = 0;
  int pops [2] = '{0, 0};

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] beat_cnt0, stall_cnt0, beat_cnt1, stall_cnt1;
`endif

  fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty[0]),
    .fifo_rd_en (rd_en[0]),
    .fifo_dout  (d1[0]),
    .m_valid    (mv[0]),
    .m_ready    (m_ready),
    .m_data     (md[0])
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .beat_cnt   (beat_cnt0),
    .stall_cnt  (stall_cnt0)
`endif
  );

  fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty[1]),
    .fifo_rd_en (rd_en[1]),
    .fifo_dout  (d2[1]),
    .m_valid    (mv[1]),
    .m_ready    (m_ready),
    .m_data     (md[1])
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .beat_cnt   (beat_cnt1),
    .stall_cnt  (stall_cnt1)
`endif
  );

  // FIFO models: registered empty flag, dout one (lane 0) or two (lane 1) clocks after rd_en.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      d2[l] <= d1[l];
      if (rd_en[l]) begin
        tests++;
        if (fifo_empty[l] || fq[l].size() == 0) begin
          fails++;
          $display("FAIL rd_while_empty lane%0d: rd_en=1 fifo_empty=%0b words=%0d",
                   l, fifo_empty[l], fq[l].size());
        end else begin
          d1[l] <= fq[l].pop_front();
        end
      end
      fifo_empty[l] <= gap || (fq[l].size() == 0);
    end
  end

  // Scoreboard and hold checker, sampled mid-cycle.
  logic [1:0]         held = '0;
  logic [1:0][DW-1:0] held_d = '0;
  always @(negedge clk) begin
    logic [DW-1:0] ew;
    #2;
    for (int l = 0; l < 2; l++) begin
      if (!rst_n) begin
        held[l] = 1'b0;
      end else begin
        if (held[l]) begin
          tests++;
          if (!mv[l] || md[l] !== held_d[l]) begin
            fails++;
            $display("FAIL hold lane%0d: m_valid=%0b m_data=0x%0h, required valid=1 data=0x%0h",
                     l, mv[l], md[l], held_d[l]);
          end
        end
        if (mv[l] && m_ready) begin
          tests++;
          pops[l]++;
          if (exq[l].size() == 0) begin
            fails++;
            $display("FAIL sb_extra lane%0d: unexpected word 0x%0h", l, md[l]);
          end else begin
            ew = exq[l].pop_front();
            if (md[l] !== ew) begin
              fails++;
              $display("FAIL sb_order lane%0d: got 0x%0h expected 0x%0h", l, md[l], ew);
            end
          end
        end
        held[l]   = mv[l] && !m_ready;
        held_d[l] = md[l];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    for (int l = 0; l < 2; l++) begin
      fq[l].push_back(w);
      exq[l].push_back(w);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string nm, input int budget);
    int k;
    k = 0;
    while ((exq[0].size() != 0 || exq[1].size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    cyc(2);
    chk({nm, "_drain_left"}, 32'(exq[0].size() + exq[1].size()), 32'd0);
  endtask

  typedef struct packed {
    logic          rdy;
    logic          rd;
    logic          v;
    logic [DW-1:0] d;
  } vec_t;
  vec_t tv [9];

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd [2], last_rd [2], nrd [2], first_mv [2], last_mv [2], nmv [2];
    logic [DW-1:0] mvd [8];
    int base0, base1, pushed, k;

    tv[0] = '{rdy: 1'b1, rd: 1'b1, v: 1'b0, d: 8'h00};
    tv[1] = '{rdy: 1'b1, rd: 1'b1, v: 1'b0, d: 8'h00};
    tv[2] = '{rdy: 1'b0, rd: 1'b0, v: 1'b1, d: 8'hA1};
    tv[3] = '{rdy: 1'b0, rd: 1'b0, v: 1'b1, d: 8'hA1};
    tv[4] = '{rdy: 1'b1, rd: 1'b1, v: 1'b1, d: 8'hA1};
    tv[5] = '{rdy: 1'b1, rd: 1'b0, v: 1'b1, d: 8'hA2};
    tv[6] = '{rdy: 1'b0, rd: 1'b0, v: 1'b1, d: 8'hA3};
    tv[7] = '{rdy: 1'b1, rd: 1'b0, v: 1'b1, d: 8'hA3};
    tv[8] = '{rdy: 1'b1, rd: 1'b0, v: 1'b0, d: 8'h00};

    rst_n = 1'b0;
    m_ready = 1'b0;
    gap = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    #1;
    chk("rst_valid0", 32'(mv[0]), 32'd0);
    chk("rst_valid1", 32'(mv[1]), 32'd0);
    chk("rst_rden0", 32'(rd_en[0]), 32'd0);
    chk("rst_data0", 32'(md[0]), 32'd0);
    @(negedge clk);
    m_ready = 1'b1;
    cyc(3);

    // Cycle-exact table on lane 0 (RD_LATENCY=1, BUF_DEPTH=2).
    push(8'hA1); push(8'hA2); push(8'hA3);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      m_ready = tv[i].rdy;
      #1;
      chk($sformatf("tbl%0d_rden", i), 32'(rd_en[0]), 32'(tv[i].rd));
      chk($sformatf("tbl%0d_valid", i), 32'(mv[0]), 32'(tv[i].v));
      if (tv[i].v) chk($sformatf("tbl%0d_data", i), 32'(md[0]), 32'(tv[i].d));
    end
    drain("tbl", 50);

    // Streaming: 8 words at full rate.
    @(negedge clk);
    m_ready = 1'b1;
    for (int w = 1; w <= 8; w++) push(DW'(w));
    for (int l = 0; l < 2; l++) begin
      first_rd[l] = -1; last_rd[l] = -1; nrd[l] = 0;
      first_mv[l] = -1; last_mv[l] = -1; nmv[l] = 0;
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
        if (rd_en[l]) begin
          if (first_rd[l] < 0) first_rd[l] = c;
          last_rd[l] = c;
          nrd[l]++;
        end
        if (mv[l]) begin
          if (first_mv[l] < 0) first_mv[l] = c;
          if (l == 0 && nmv[l] < 8) mvd[nmv[l]] = md[0];
          last_mv[l] = c;
          nmv[l]++;
        end
      end
    end
    chk("stream_nrd0", 32'(nrd[0]), 32'd8);
    chk("stream_rd_span0", 32'(last_rd[0] - first_rd[0]), 32'd7);
    chk("stream_lat0", 32'(first_mv[0] - first_rd[0]), 32'd2);
    chk("stream_nmv0", 32'(nmv[0]), 32'd8);
    chk("stream_mv_span0", 32'(last_mv[0] - first_mv[0]), 32'd7);
    for (int w = 0; w < 8; w++) chk($sformatf("stream_data%0d", w), 32'(mvd[w]), 32'(w + 1));
    chk("stream_nrd1", 32'(nrd[1]), 32'd8);
    chk("stream_lat1", 32'(first_mv[1] - first_rd[1]), 32'd3);
    chk("stream_mv_span1", 32'(last_mv[1] - first_mv[1]), 32'd7);
    drain("stream", 50);

    // Back-pressure: only BUF_DEPTH reads issued while m_ready=0.
    @(negedge clk);
    m_ready = 1'b0;
    for (int w = 0; w < 8; w++) push(DW'(8'h10 + w));
    nrd[0] = 0; nrd[1] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      for (int l = 0; l < 2; l++) if (rd_en[l]) nrd[l]++;
    end
    chk("bp_pulses0", 32'(nrd[0]), 32'd2);
    chk("bp_pulses1", 32'(nrd[1]), 32'd3);
    chk("bp_valid0", 32'(mv[0]), 32'd1);
    chk("bp_data0", 32'(md[0]), 32'h10);
    chk("bp_data1", 32'(md[1]), 32'h10);
    base0 = pops[0];
    @(negedge clk);
    m_ready = 1'b1;
    drain("bp", 60);
    chk("bp_pops0", 32'(pops[0] - base0), 32'd8);

    // Empty gap: valid drops after word 3, resumes with word 4.
    @(negedge clk);
    push(8'h21); push(8'h22); push(8'h23);
    cyc(8);
    #1;
    chk("gap_valid0", 32'(mv[0]), 32'd0);
    chk("gap_valid1", 32'(mv[1]), 32'd0);
    chk("gap_rden0", 32'(rd_en[0]), 32'd0);
    @(negedge clk);
    push(8'h24); push(8'h25); push(8'h26);
    drain("gap", 50);
    // Empty flag forced high with words queued: nothing may be read.
    @(negedge clk);
    gap = 1'b1;
    push(8'h27); push(8'h28);
    cyc(6);
    #1;
    chk("forced_empty_valid0", 32'(mv[0]), 32'd0);
    chk("forced_empty_words0", 32'(fq[0].size()), 32'd2);
    @(negedge clk);
    gap = 1'b0;
    drain("forced_empty", 50);

    // Random m_ready and empty gaps over 1000 words.
    base0 = pops[0];
    base1 = pops[1];
    pushed = 0;
    k = 0;
    while ((pushed < 1000 || exq[0].size() != 0 || exq[1].size() != 0) && k < 20000) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      gap = ($urandom_range(0, 9) == 0);
      if (pushed < 1000 && fq[0].size() < 16 && $urandom_range(0, 3) != 0) begin
        push(DW'(pushed * 7 + 3));
        pushed++;
      end
      k++;
    end
    @(negedge clk);
    gap = 1'b0;
    m_ready = 1'b1;
    cyc(4);
    chk("rand_budget", 32'(k < 20000), 32'd1);
    chk("rand_pops0", 32'(pops[0] - base0), 32'd1000);
    chk("rand_pops1", 32'(pops[1] - base1), 32'd1000);

    // Reset mid-stream with two words buffered.
    @(negedge clk);
    m_ready = 1'b0;
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    cyc(8);
    #1;
    chk("pre_rst_valid0", 32'(mv[0]), 32'd1);
    chk("pre_rst_data0", 32'(md[0]), 32'h31);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid0", 32'(mv[0]), 32'd0);
    chk("rst_mid_rden0", 32'(rd_en[0]), 32'd0);
    chk("rst_mid_valid1", 32'(mv[1]), 32'd0);
    chk("rst_mid_rden1", 32'(rd_en[1]), 32'd0);
    for (int l = 0; l < 2; l++) begin
      fq[l].delete();
      exq[l].delete();
    end
    cyc(3);
    rst_n = 1'b1;
    m_ready = 1'b1;
    nmv[0] = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (mv[0] || mv[1]) nmv[0]++;
    end
    chk("post_rst_stale", 32'(nmv[0]), 32'd0);

`ifdef FIFO_RD_STREAM_STATS_EN
    // 100 beats with exactly 20 stalled cycles on lane 0.
    @(negedge clk);
    m_ready = 1'b0;
    for (int w = 0; w < 100; w++) push(DW'(w + 8'h40));
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!mv[0] && k < 20);
    chk("stats_valid_seen", 32'(mv[0]), 32'd1);
    cyc(19);
    @(negedge clk);
    m_ready = 1'b1;
    drain("stats", 400);
    chk("stats_beat_cnt", beat_cnt0, 32'd100);
    chk("stats_stall_cnt", stall_cnt0, 32'd20);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
